// File: rtl/aes_word_counter_bank.sv
`default_nettype none
// ============================================================================
//  Module   : aes_word_counter_bank
//  Purpose  : Per-stream accepted-beat counters with sticky overflow flags,
//             exposed through an Avalon-MM slave. Optional COUNT shadowing
//             is enabled with `define AES_CNT_SNAPSHOT_EN.
//  Revision : 1.0 - initial release
// ============================================================================
module aes_word_counter_bank #(
    parameter int                      NUM_CHANNELS = 3,
    parameter int                      COUNTER_SIZE = 8,
    parameter int                      ADDRESS_SIZE = 32,
    parameter int                      REG_SIZE     = 32,
    parameter logic [ADDRESS_SIZE-1:0] BASE_ADDR    = 'h1000,
    parameter bit                      SATURATE     = 1'b0
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic [NUM_CHANNELS-1:0] cnt_valid,
    input  logic [NUM_CHANNELS-1:0] cnt_ready,
    input  logic [ADDRESS_SIZE-1:0] avs_address,
    input  logic                    avs_read,
    input  logic                    avs_write,
    input  logic [REG_SIZE-1:0]     avs_writedata,
    output logic [REG_SIZE-1:0]     avs_readdata,
    output logic                    avs_readdatavalid,
    output logic                    avs_waitrequest,
    output logic [NUM_CHANNELS-1:0] cnt_overflow
);

    localparam logic [ADDRESS_SIZE-1:0] c_window_bytes = ADDRESS_SIZE'(4 * (NUM_CHANNELS + 2));
    localparam logic [4:0]              c_ctrl_idx     = 5'(NUM_CHANNELS);
    localparam logic [4:0]              c_ovf_idx      = 5'(NUM_CHANNELS + 1);

    logic [ADDRESS_SIZE-1:0]              w_offset;
    logic [4:0]                           w_idx;
    logic                                 w_hit;
    logic                                 w_wr_hit;
    logic                                 w_ctrl_wr;
    logic                                 w_ovf_wr;
    logic                                 w_clear;
    logic                                 r_freeze;
    logic [NUM_CHANNELS*COUNTER_SIZE-1:0] w_rd_cnt_flat;
    logic [NUM_CHANNELS-1:0]              w_ovf_vec;
    logic [REG_SIZE-1:0]                  w_rd_data;
    logic [REG_SIZE-1:0]                  r_readdata;
    logic                                 r_readdatavalid;
    logic                                 w_unused;

    // Window is NUM_CHANNELS COUNT words followed by CTRL and OVF.
    assign w_offset  = avs_address - BASE_ADDR;
    assign w_idx     = w_offset[6:2];
    assign w_hit     = (avs_address >= BASE_ADDR) && (w_offset < c_window_bytes) &&
                       (avs_address[1:0] == 2'b00);
    assign w_wr_hit  = avs_write && w_hit;
    assign w_ctrl_wr = w_wr_hit && (w_idx == c_ctrl_idx);
    assign w_ovf_wr  = w_wr_hit && (w_idx == c_ovf_idx);
    assign w_clear   = w_ctrl_wr && avs_writedata[0];
    assign w_unused  = ^avs_writedata;

`ifdef AES_CNT_SNAPSHOT_EN
    logic w_snap;
    assign w_snap = w_ctrl_wr && avs_writedata[2];
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_freeze <= 1'b0;
        end else if (w_ctrl_wr) begin
            r_freeze <= avs_writedata[1];
        end
    end

    for (genvar i = 0; i < NUM_CHANNELS; i++) begin : g_ch
        localparam logic [4:0] c_ch_idx = 5'(i);

        logic [COUNTER_SIZE-1:0] r_cnt;
        logic [COUNTER_SIZE-1:0] w_cnt_nxt;
        logic                    r_ovf;
        logic                    w_wr_cnt;
        logic                    w_inc;
        logic                    w_at_max;
        logic                    w_ovf_clr;

        assign w_wr_cnt  = w_wr_hit && (w_idx == c_ch_idx);
        // A beat only counts when nothing higher-priority touches the counter.
        assign w_inc     = cnt_valid[i] && cnt_ready[i] && !r_freeze && !w_clear && !w_wr_cnt;
        assign w_at_max  = &r_cnt;
        assign w_ovf_clr = w_clear || (w_ovf_wr && avs_writedata[i]);

        always_comb begin
            w_cnt_nxt = r_cnt;
            if (w_clear) begin
                w_cnt_nxt = '0;
            end else if (w_wr_cnt) begin
                w_cnt_nxt = avs_writedata[COUNTER_SIZE-1:0];
            end else if (w_inc) begin
                if (!w_at_max) begin
                    w_cnt_nxt = r_cnt + COUNTER_SIZE'(1);
                end else if (!SATURATE) begin
                    w_cnt_nxt = '0;
                end
            end
        end

        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                r_cnt <= '0;
                r_ovf <= 1'b0;
            end else begin
                r_cnt <= w_cnt_nxt;
                // Set has priority over a coincident clear.
                r_ovf <= (w_inc && w_at_max) || (r_ovf && !w_ovf_clr);
            end
        end

`ifdef AES_CNT_SNAPSHOT_EN
        logic [COUNTER_SIZE-1:0] r_shadow;

        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                r_shadow <= '0;
            end else if (w_snap) begin
                r_shadow <= r_cnt;
            end
        end

        assign w_rd_cnt_flat[i*COUNTER_SIZE +: COUNTER_SIZE] = r_shadow;
`else
        assign w_rd_cnt_flat[i*COUNTER_SIZE +: COUNTER_SIZE] = r_cnt;
`endif
        assign w_ovf_vec[i] = r_ovf;
    end

    always_comb begin
        w_rd_data = '0;
        if (w_hit) begin
            if (w_idx == c_ctrl_idx) begin
                w_rd_data[1] = r_freeze;
            end else if (w_idx == c_ovf_idx) begin
                w_rd_data[NUM_CHANNELS-1:0] = w_ovf_vec;
            end else begin
                for (int k = 0; k < NUM_CHANNELS; k++) begin
                    if (int'(w_idx) == k) begin
                        w_rd_data[COUNTER_SIZE-1:0] = w_rd_cnt_flat[k*COUNTER_SIZE +: COUNTER_SIZE];
                    end
                end
            end
        end
    end

    // Read data is captured from pre-update state, so it reflects this cycle's
    // value even when a write or beat lands on the same edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_readdata      <= '0;
            r_readdatavalid <= 1'b0;
        end else begin
            r_readdatavalid <= avs_read;
            if (avs_read) begin
                r_readdata <= w_rd_data;
            end
        end
    end

    assign avs_readdata      = r_readdata;
    assign avs_readdatavalid = r_readdatavalid;
    assign avs_waitrequest   = 1'b0;
    assign cnt_overflow      = w_ovf_vec;

endmodule
`default_nettype wire

// File: doc/aes_word_counter_bank.md
Name: aes_word_counter_bank

Overview:
- Parametrised bank of NUM_CHANNELS word counters for the AES datapath. Channel 0 is message in, 1 is adder out, 2 is remover out; further channels are allowed.
- Each counter increments on every accepted beat (valid & ready) of its stream.
- Counters, per-channel overflow flags and a control register are exposed through an Avalon-MM slave in the peripheral address window.

Parameters:
- NUM_CHANNELS, 3, number of counted streams (1..16).
- COUNTER_SIZE, 8, counter width in bits (1..REG_SIZE).
- ADDRESS_SIZE, 32, Avalon address width.
- REG_SIZE, 32, Avalon data width.
- BASE_ADDR, 'h1000, byte base address of the bank.
- SATURATE, 0, 0 = counters wrap, 1 = counters hold at all-ones.

Ports:
- clk  in  1  single clock.
- rst_n  in  1  reset, asynchronous, active-low.
- cnt_valid  in  NUM_CHANNELS  per-channel stream valid.
- cnt_ready  in  NUM_CHANNELS  per-channel stream ready; a beat counts when valid & ready.
- avs_address  in  ADDRESS_SIZE  byte address.
- avs_read  in  1  read strobe.
- avs_write  in  1  write strobe.
- avs_writedata  in  REG_SIZE  write data.
- avs_readdata  out  REG_SIZE  read data.
- avs_readdatavalid  out  1  read data qualifier.
- avs_waitrequest  out  1  constant 0.
- cnt_overflow  out  NUM_CHANNELS  sticky overflow flags, one per channel.

Behaviour:
- Reset (async, rst_n=0): all counters, cnt_overflow, control and avs_readdata are 0; avs_readdatavalid=0.
- Register map (offsets from BASE_ADDR):
  - 4*i: COUNT[i], read/write; value zero-extended to REG_SIZE.
  - 4*NUM_CHANNELS: CTRL.
    - bit0 CLEAR: write-1 self-clearing pulse; zeroes all counters.
    - bit1 FREEZE: read/write; while set, counters do not increment.
    - bit2 SNAP: write-1 pulse; used only with the optional feature.
  - 4*NUM_CHANNELS+4: OVF, bit i = cnt_overflow[i], write-1-to-clear.
- Address decode:
  - Access hits only if the address is inside the window and word-aligned (address[1:0]=0).
  - Writes that miss are ignored.
  - Reads that miss return 0 and still assert avs_readdatavalid.
- Read latency is exactly 1 cycle. Read in cycle N gives avs_readdatavalid=1 and avs_readdata in cycle N+1. avs_readdata holds its last value when readdatavalid=0.
- The value read is the register state before any same-cycle update (pre-increment).
- avs_read and avs_write asserted in the same cycle: the write executes; the read still returns in N+1 with the pre-write value.
- Counter update, per channel, per cycle, priority highest first:
  1. CLEAR → 0.
  2. Write to COUNT[i] → writedata[COUNTER_SIZE-1:0]; the beat in that cycle is dropped.
  3. FREEZE=1 → hold.
  4. valid & ready → increment.
  5. Otherwise hold.
- Increment at all-ones:
  - SATURATE=0: wraps to 0.
  - SATURATE=1: holds all-ones.
  - Either mode: cnt_overflow[i] is set in the next cycle.
- cnt_overflow[i]:
  - Cleared by writing 1 to OVF bit i, or by CLEAR.
  - If an overflow and a clear coincide, the set wins.
  - Unaffected by FREEZE.
- CTRL bits above bit2 read 0; CLEAR and SNAP read 0.
- Reset asserted mid-transaction: a pending readdatavalid is dropped.

Optional Feature:
- Macro: AES_CNT_SNAPSHOT_EN.
- Defined:
  - A shadow register per channel is added.
  - Writing SNAP=1 copies all live counters into the shadows atomically in one cycle.
  - COUNT[i] reads return the shadow value; writes still target the live counter.
  - Shadows reset to 0. CLEAR does not touch the shadows.
- Undefined:
  - No shadow registers; SNAP is ignored.
  - COUNT reads return the live counter.

Test Plan:
- Reset then read 'h1000, 'h1004, 'h1008 → readdatavalid one cycle after each read; data 0,0,0; cnt_overflow=0.
- Channel 1 valid&ready for 5 cycles, with ready low in 2 of them → read 'h1004 returns 3; the other channels read 0.
- SATURATE=0, COUNTER_SIZE=8: write 'h1000=8'hFE, then 3 beats → count 1, cnt_overflow[0]=1. Write OVF ('h1010)=1 → flag cleared.
- SATURATE=1, same stimulus → count 'hFF, cnt_overflow[0]=1.
- CTRL='h1 written in the same cycle as beats on all channels → all counts 0. CTRL='h2 then 4 beats → counts unchanged; read CTRL → 'h2.
- With AES_CNT_SNAPSHOT_EN: count ch0 to 7, write SNAP, then 2 more beats → read 'h1000=7. Second SNAP → read 'h1000=9. Read 'h1014 (out of window) → 0 with readdatavalid.
